// File: rtl/mem_bus_arbiter.sv
// Shares the single external memory port between icache (0), dcache (1) and uncached (2)
// requesters, one whole transaction at a time, with an aging counter that protects icache.
module mem_bus_arbiter #(
    parameter int ADDR_WD   = 32,
    parameter int DATA_WD   = 32,
    parameter int AGE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [2:0]           req,
    input  logic [2:0]           req_we,
    input  logic [3*ADDR_WD-1:0] req_addr,
    input  logic [3*8-1:0]       req_len,
    input  logic [3*DATA_WD-1:0] req_wdata,
    output logic [2:0]           gnt,
    output logic [2:0]           rvalid,
    output logic [DATA_WD-1:0]   rdata,
    output logic                 rlast,
    output logic [2:0]           wready,
    output logic [2:0]           wdone,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_WD-1:0]   mem_addr,
    output logic [7:0]           mem_len,
    input  logic                 mem_ack,
    input  logic                 mem_rvalid,
    input  logic                 mem_rlast,
    input  logic [DATA_WD-1:0]   mem_rdata,
    output logic                 mem_wvalid,
    output logic                 mem_wlast,
    output logic [DATA_WD-1:0]   mem_wdata,
    input  logic                 mem_wready,
    input  logic                 mem_bvalid
);

    localparam int AGE_WD = $clog2(AGE_LIMIT + 1);
    localparam logic [AGE_WD-1:0] AGE_MAX = AGE_WD'(AGE_LIMIT);
    localparam logic [AGE_WD-1:0] AGE_ONE = AGE_WD'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_RDATA = 3'd2,
        ST_WDATA = 3'd3,
        ST_WRESP = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_WD-1:0]  addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [AGE_WD-1:0]   age_q, age_d;

    logic [1:0]          winner_s;
    logic                win_we_s;
    logic [ADDR_WD-1:0]  win_addr_s;
    logic [7:0]          win_len_s;
    logic [2:0]          own_oh_s;
    logic [DATA_WD-1:0]  own_wdata_s;

    // Arbitration: a starved icache beats everyone, otherwise fixed priority 2 > 1 > 0.
    always_comb begin
        winner_s = 2'd0;
        if (req[0] && (age_q == AGE_MAX)) begin
            winner_s = 2'd0;
        end else if (req[2]) begin
            winner_s = 2'd2;
        end else if (req[1]) begin
            winner_s = 2'd1;
        end else begin
            winner_s = 2'd0;
        end
        case (winner_s)
            2'd1: begin
                win_we_s   = req_we[1];
                win_addr_s = req_addr[ADDR_WD +: ADDR_WD];
                win_len_s  = req_len[15:8];
            end
            2'd2: begin
                win_we_s   = req_we[2];
                win_addr_s = req_addr[2*ADDR_WD +: ADDR_WD];
                win_len_s  = req_len[23:16];
            end
            default: begin
                win_we_s   = req_we[0];
                win_addr_s = req_addr[0 +: ADDR_WD];
                win_len_s  = req_len[7:0];
            end
        endcase
    end

    // Owner decode: one-hot routing mask and the owner's current write beat.
    always_comb begin
        case (owner_q)
            2'd1: begin
                own_oh_s    = 3'b010;
                own_wdata_s = req_wdata[DATA_WD +: DATA_WD];
            end
            2'd2: begin
                own_oh_s    = 3'b100;
                own_wdata_s = req_wdata[2*DATA_WD +: DATA_WD];
            end
            default: begin
                own_oh_s    = 3'b001;
                own_wdata_s = req_wdata[0 +: DATA_WD];
            end
        endcase
    end

    // Next-state logic for the transaction FSM, latched request fields and aging.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        age_d   = age_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    owner_d = winner_s;
                    we_d    = win_we_s;
                    addr_d  = win_addr_s;
                    len_d   = win_len_s;
                    state_d = ST_ADDR;
                    if (winner_s == 2'd0) begin
                        age_d = '0;
                    end else if (req[0] && (age_q != AGE_MAX)) begin
                        age_d = age_q + AGE_ONE;
                    end else begin
                        age_d = age_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (mem_ack) begin
                    cnt_d   = len_q;
                    state_d = we_q ? ST_WDATA : ST_RDATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_RDATA: begin
                // Memory's rlast ends the burst; the requested length is not enforced on reads.
                if (mem_rvalid && mem_rlast) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_WDATA: begin
                if (mem_wready) begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_WRESP;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_WRESP: begin
                if (mem_bvalid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WRESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            owner_q <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
            age_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            age_q   <= age_d;
        end
    end

    // Output decode: handshakes pass through with zero latency, gated to the owner and state.
    always_comb begin
        gnt        = 3'b000;
        rvalid     = 3'b000;
        rdata      = '0;
        rlast      = 1'b0;
        wready     = 3'b000;
        wdone      = 3'b000;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_len    = 8'd0;
        mem_wvalid = 1'b0;
        mem_wlast  = 1'b0;
        mem_wdata  = '0;
        case (state_q)
            ST_ADDR: begin
                mem_req  = 1'b1;
                mem_we   = we_q;
                mem_addr = addr_q;
                mem_len  = len_q;
                gnt      = mem_ack ? own_oh_s : 3'b000;
            end
            ST_RDATA: begin
                rvalid = mem_rvalid ? own_oh_s : 3'b000;
                rdata  = mem_rdata;
                rlast  = mem_rlast;
            end
            ST_WDATA: begin
                mem_wvalid = 1'b1;
                mem_wdata  = own_wdata_s;
                mem_wlast  = (cnt_q == 8'd0);
                wready     = mem_wready ? own_oh_s : 3'b000;
            end
            ST_WRESP: begin
                wdone = mem_bvalid ? own_oh_s : 3'b000;
            end
            default: begin
                gnt = 3'b000;
            end
        endcase
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single external memory port between the core's three miss/uncached requesters: icache refill (index 0), dcache refill/writeback (index 1) and uncached load/store (index 2). It sits between the caches and the bus bridge, where `stallreq_icache`, `stallreq_dcache` and `stallreq_uncache` originate. It serialises whole transactions (address phase, then a burst of data beats, then a write response) and guarantees icache forward progress with an aging counter.

## Interface
Parameters:
- ADDR_WD, 32, address width
- DATA_WD, 32, data beat width
- AGE_LIMIT, 8, lost arbitrations before icache is forced to win; must be ≥1

Ports (vectors packed, requester i at bits [i*W +: W]):
- clk  in  1  clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- req  in  3  transaction request; held until matching gnt
- req_we  in  3  1 = write, 0 = read
- req_addr  in  3*ADDR_WD  start address
- req_len  in  3*8  beats minus one (0..255)
- req_wdata  in  3*DATA_WD  current write beat; valid whenever wready may fire
- gnt  out  3  one-hot, address accepted by memory
- rvalid  out  3  read beat valid for owner
- rdata  out  DATA_WD  read beat data, shared
- rlast  out  1  last read beat
- wready  out  3  write beat consumed by memory
- wdone  out  3  write response received
- mem_req / mem_we  out  1  address phase valid / direction
- mem_addr  out  ADDR_WD; mem_len  out  8
- mem_ack  in  1  address accepted
- mem_rvalid, mem_rlast  in  1; mem_rdata  in  DATA_WD
- mem_wvalid, mem_wlast  out  1; mem_wdata  out  DATA_WD
- mem_wready, mem_bvalid  in  1

## Operation
- FSM states IDLE, ADDR, RDATA, WDATA, WRESP; owner index, we, addr, len latched in registers.
- IDLE: if any req, select winner: if req[0] and age == AGE_LIMIT → 0; else priority 2 > 1 > 0. Latch winner's fields, go ADDR. No req → stay.
- Age: on each IDLE decision with req[0]=1 and winner≠0, age += 1, saturating at AGE_LIMIT; cleared to 0 when 0 wins.
- ADDR: mem_req=1, mem_we/addr/len from latched regs. On mem_ack: gnt[owner]=1 this cycle; beat counter ← len; go RDATA if read, WDATA if write.
- RDATA: rvalid[owner]=mem_rvalid, rdata=mem_rdata, rlast=mem_rlast (combinational). On mem_rvalid & mem_rlast → IDLE. rlast governs end; len is not checked on reads.
- WDATA: mem_wvalid=1, mem_wdata=req_wdata[owner], mem_wlast=(counter==0), wready[owner]=mem_wready. Each mem_wready: counter −1; on last beat → WRESP.
- WRESP: on mem_bvalid: wdone[owner]=1, → IDLE.
- All per-requester outputs for non-owners are 0. mem_rvalid/mem_bvalid outside RDATA/WRESP ignored.
- Requests are not cancellable once latched; a requester dropping req before gnt is a protocol violation.

## Timing
- Reset (resetn low, asynchronous): state IDLE, age 0, counter 0, latched regs 0; every output 0. Reset mid-transaction aborts immediately; memory side must be reset together.
- req rising in cycle N (IDLE) → mem_req at N+1; gnt earliest N+1 (same cycle as mem_ack).
- Read beats pass through with zero latency; write beats zero latency (wready = mem_wready).
- Turnaround: last beat/bvalid in cycle M → IDLE at M+1 → next mem_req at M+2. Minimum one idle cycle between transactions.
- len=0: single beat, mem_wlast high on first WDATA cycle. len=255: 256 beats, counter 8 bits, no wrap.
- Simultaneous req on all three at IDLE with age<AGE_LIMIT → uncached wins.

## Test plan
- Single icache read, addr 0x1c000000, len 3: mem_req one cycle after req; gnt[0] with mem_ack; 4 rvalid[0] pulses, rlast on 4th; IDLE next cycle.
- req=3'b111 all held, no aging: grant order 2, 1, 0; age reaches 2 before icache wins, cleared after.
- AGE_LIMIT=2, dcache reads back-to-back continuously, icache req held: icache wins 3rd decision despite req[1]=1.
- Uncached write len 0, data 0xdeadbeef: mem_wlast=1 with mem_wdata=0xdeadbeef on first WDATA cycle; wdone[2] pulse on mem_bvalid; mem_wready stalls of 3 cycles hold state.
- Dcache write len 7 with mem_wready toggling: exactly 8 wready[1] pulses, mem_wlast only on 8th.
- resetn low mid-RDATA beat 2: all outputs 0 immediately; after release, fresh req re-arbitrates from IDLE with age 0.
